pwm_decoder: RTL and testbench

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_decoder.sv | 147 ++++++++++++++
 tb/tb_pwm_decoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// PWM decoder: measures period and high time of an asynchronous PWM input and
// reports duty cycle in percent via a 7-step restoring divider.
module pwm_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             clr_flags,
  output logic [6:0]       duty_pct,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             duty_valid,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int DW     = CNT_W + 7;
  localparam int STAGES = 7;

  typedef enum logic {IDLE, MEASURE} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } meas_t;

  state_t           state, state_nxt;
  logic             sync_m, sync, sync_d, rise;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             capture, tmo_evt, div_start, div_drop, div_run;
  logic [STAGES:0]  vld_pipe;
  logic [DW-1:0]    rem, dvs;
  logic             rem_ge;
  logic [6:0]       quo;
  meas_t            cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_m <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync_m <= pwm_in;
      sync   <= sync_m;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    tmo_evt   = 1'b0;
    case (state)
      IDLE:    if (rise) state_nxt = MEASURE;
      MEASURE: begin
        if (rise) capture = 1'b1;
        else if (period_cnt == CNT_MAX) begin
          tmo_evt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // vld_pipe[0..STAGES-1] mark quotient-bit cycles; the finishing cycle may accept a new start.
  assign div_run   = |vld_pipe[STAGES-1:0];
  assign div_start = capture & ~div_run;
  assign div_drop  = capture &  div_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(1);
    end else if (state == MEASURE && !tmo_evt) begin
      period_cnt <= period_cnt + CNT_W'(1);
      if (sync) high_cnt <= high_cnt + CNT_W'(1);
    end
  end

  // high <= period keeps the quotient below 128, so 7 restoring steps suffice.
  assign rem_ge = (rem >= dvs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rem      <= '0;
      dvs      <= '0;
      quo      <= '0;
      cap      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], div_start};
      if (div_start) begin
        rem        <= DW'(high_cnt) * DW'(100);
        dvs        <= DW'(period_cnt) << 6;
        quo        <= '0;
        cap.period <= period_cnt;
        cap.high   <= high_cnt;
      end else if (div_run) begin
        if (rem_ge) rem <= rem - dvs;
        quo <= {quo[5:0], rem_ge};
        dvs <= dvs >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_pct   <= '0;
      period_out <= '0;
      high_out   <= '0;
      duty_valid <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (vld_pipe[STAGES]) begin
        duty_pct   <= quo;
        period_out <= cap.period;
        high_out   <= cap.high;
        duty_valid <= 1'b1;
      end else if (tmo_evt) begin
        duty_pct   <= sync ? 7'd100 : 7'd0;
        period_out <= '0;
        high_out   <= '0;
        duty_valid <= 1'b1;
      end
      if (tmo_evt)                    timeout <= 1'b1;
      else if (state == IDLE && rise) timeout <= 1'b0;
      if (div_drop)       overrun <= 1'b1;
      else if (clr_flags) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: waveforms are built as per-cycle level lists and checked
// against an edge-list reference model evaluated cycle by cycle.
module tb_pwm_decoder;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int ML    = 1024;

  logic             clk = 1'b0, rst_n = 1'b0, pwm_in = 1'b0, clr_flags = 1'b0;
  logic [6:0]       duty_pct;
  logic [CNT_W-1:0] period_out, high_out;
  logic             duty_valid, timeout, overrun;

  int n_chk = 0, n_err = 0;
  bit lvl[$];
  bit clq[$];
  int e_vld[ML], e_duty[ML], e_per[ML], e_high[ML], e_tmo[ML], e_ovr[ML];

  pwm_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .clr_flags(clr_flags),
    .duty_pct(duty_pct), .period_out(period_out), .high_out(high_out),
    .duty_valid(duty_valid), .timeout(timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  task automatic add_lows(input int k);
    repeat (k) begin lvl.push_back(1'b0); clq.push_back(1'b0); end
  endtask

  task automatic add_pwm(input int p, input int h, input int cnt);
    repeat (cnt)
      for (int i = 0; i < p; i++) begin lvl.push_back(bit'(i < h)); clq.push_back(1'b0); end
  endtask

  // Edge t of pwm_in is seen by the decoder at clock t+2; results land 8 clocks later.
  task automatic build_model(input int len);
    bit up[ML]; int ud[ML], upr[ML], uh[ML];
    bit tset[ML], tclr[ML], oset[ML];
    int start = 0, last_acc = -1000, per, hi;
    bit meas = 1'b0;
    int cd = 0, cp = 0, ch = 0, tmo = 0, ovr = 0;
    for (int t = 0; t < len; t++) begin
      if (meas && t - start > MAXC) begin
        if (t + 1 < len) begin
          up[t+1] = 1'b1; ud[t+1] = lvl[start+MAXC] ? 100 : 0;
          upr[t+1] = 0; uh[t+1] = 0; tset[t+1] = 1'b1;
        end
        meas = 1'b0;
      end
      if (lvl[t] && (t == 0 || !lvl[t-1])) begin
        if (!meas) begin
          meas = 1'b1; start = t;
          if (t + 2 < len) tclr[t+2] = 1'b1;
        end else begin
          per = t - start; hi = 0;
          for (int k = start; k < t; k++) hi += int'(lvl[k]);
          if (t - last_acc >= 8) begin
            last_acc = t;
            if (t + 10 < len) begin
              up[t+10] = 1'b1; ud[t+10] = hi * 100 / per; upr[t+10] = per; uh[t+10] = hi;
            end
          end else if (t + 2 < len) oset[t+2] = 1'b1;
          start = t;
        end
      end
    end
    for (int n = 0; n < len; n++) begin
      if (up[n]) begin cd = ud[n]; cp = upr[n]; ch = uh[n]; end
      if (tset[n]) tmo = 1; else if (tclr[n]) tmo = 0;
      if (oset[n]) ovr = 1; else if (clq[n]) ovr = 0;
      e_vld[n] = int'(up[n]); e_duty[n] = cd; e_per[n] = cp; e_high[n] = ch;
      e_tmo[n] = tmo; e_ovr[n] = ovr;
    end
  endtask

  task automatic run_seg(input string nm);
    int len;
    len = lvl.size();
    build_model(len);
    for (int n = 0; n < len; n++) begin
      pwm_in = lvl[n]; clr_flags = clq[n];
      @(posedge clk); @(negedge clk);
      check({nm, ".valid"},   duty_valid, e_vld[n]);
      check({nm, ".duty"},    duty_pct,   e_duty[n]);
      check({nm, ".period"},  period_out, e_per[n]);
      check({nm, ".high"},    high_out,   e_high[n]);
      check({nm, ".timeout"}, timeout,    e_tmo[n]);
      check({nm, ".overrun"}, overrun,    e_ovr[n]);
    end
    pwm_in = 1'b0; clr_flags = 1'b0;
    lvl.delete(); clq.delete();
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0; pwm_in = 1'b0; clr_flags = 1'b0;
    #1;
    check({nm, ".duty"},    duty_pct,   0);
    check({nm, ".period"},  period_out, 0);
    check({nm, ".high"},    high_out,   0);
    check({nm, ".valid"},   duty_valid, 0);
    check({nm, ".timeout"}, timeout,    0);
    check({nm, ".overrun"}, overrun,    0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, h;
    @(negedge clk);
    do_reset("rst0");
    add_lows(3); add_pwm(10, 3, 8); add_lows(12);
    run_seg("p10h3");

    do_reset("rst1");
    add_lows(1); add_pwm(30, 10, 4); add_pwm(20, 10, 4); add_lows(12);
    run_seg("p30p20");

    do_reset("rst2");
    add_lows(2); add_pwm(6, 3, 12); add_lows(12);
    for (int i = 20; i < clq.size(); i++) clq[i] = (i % 5 == 0);
    run_seg("ovr6");

    do_reset("rst3");
    add_pwm(8, 4, 6); add_pwm(7, 2, 6); add_lows(12);
    run_seg("p8p7");

    do_reset("rst4");
    add_lows(2); add_pwm(299, 299, 1); add_lows(2); add_pwm(10, 3, 4); add_lows(12);
    run_seg("tmo");

    // Reset lands four clocks into the divide started by the third edge.
    do_reset("rst5");
    add_lows(3); add_pwm(10, 3, 3);
    while (lvl.size() > 29) begin void'(lvl.pop_back()); void'(clq.pop_back()); end
    run_seg("middiv");
    do_reset("rst_mid");
    add_lows(1); add_pwm(10, 3, 5); add_lows(12);
    run_seg("after_rst");

    for (int r = 0; r < 6; r++) begin
      do_reset("rst_rnd");
      add_lows($urandom_range(0, 3));
      repeat (10) begin
        p = $urandom_range(2, 40); h = $urandom_range(1, p - 1);
        add_pwm(p, h, 1);
      end
      add_lows(12);
      for (int i = 0; i < clq.size(); i++) clq[i] = ($urandom_range(0, 15) == 0);
      run_seg("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
